// File: rtl/fifo_sync_ctl.sv
// fifo_sync_ctl: valid/ready stream FIFO controller around an external dual-port RAM
// with a registered read address. Optional flags: define FIFO_SYNC_ALMOST_EN.
module fifo_sync_ctl #(
   parameter int ADDR_WIDTH    = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH+1:0] count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam logic [ADDR_WIDTH:0]   RAM_FULL_C = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   PTR_ONE_C  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH+1:0] AFULL_C    = AFULL_THRESH[ADDR_WIDTH+1:0];
   localparam logic [ADDR_WIDTH+1:0] AEMPTY_C   = AEMPTY_THRESH[ADDR_WIDTH+1:0];

   logic [ADDR_WIDTH:0]   wr_ptr_r, rd_ptr_r, wr_ptr_n_s, rd_ptr_n_s, ram_occ_s;
   logic                  pend_r, pend_n_s;
   logic [1:0]            skid_occ_r, skid_occ_n_s, inflight_s, land_slot_s;
   logic [DATA_WIDTH-1:0] skid0_r, skid1_r, skid0_n_s, skid1_n_s;
   logic                  full_s, in_ready_s, in_hs_s, out_valid_s, out_hs_s, fetch_s;
   logic [ADDR_WIDTH+1:0] count_s;

   assign ram_occ_s   = wr_ptr_r - rd_ptr_r;
   assign full_s      = (ram_occ_s == RAM_FULL_C) & ~reset;
   assign in_ready_s  = ~full_s & ~reset;
   assign in_hs_s     = in_valid & in_ready_s;
   assign out_valid_s = (skid_occ_r != 2'd0) & ~reset;
   assign out_hs_s    = out_valid_s & out_ready;

   // Words that will occupy the skid next cycle before any new fetch lands.
   assign inflight_s  = skid_occ_r + {1'b0, pend_r} - {1'b0, out_hs_s};
   assign fetch_s     = (ram_occ_s != {(ADDR_WIDTH+1){1'b0}}) & (inflight_s < 2'd2) & ~reset;
   assign land_slot_s = skid_occ_r - {1'b0, out_hs_s};

   assign count_s = reset ? {(ADDR_WIDTH+2){1'b0}}
                          : {1'b0, ram_occ_s}
                            + {{(ADDR_WIDTH+1){1'b0}}, pend_r}
                            + {{ADDR_WIDTH{1'b0}}, skid_occ_r};

   // Next-state for pointers, pending fetch and skid buffer.
   always_comb begin
      wr_ptr_n_s   = wr_ptr_r;
      rd_ptr_n_s   = rd_ptr_r;
      skid0_n_s    = skid0_r;
      skid1_n_s    = skid1_r;
      skid_occ_n_s = skid_occ_r;
      pend_n_s     = fetch_s;
      if (in_hs_s) begin
         wr_ptr_n_s = wr_ptr_r + PTR_ONE_C;
      end else begin
         wr_ptr_n_s = wr_ptr_r;
      end
      if (fetch_s) begin
         rd_ptr_n_s = rd_ptr_r + PTR_ONE_C;
      end else begin
         rd_ptr_n_s = rd_ptr_r;
      end
      if (out_hs_s) begin
         skid0_n_s = skid1_r;
      end else begin
         skid0_n_s = skid0_r;
      end
      // Landing goes to the first slot left free after any shift.
      if (pend_r) begin
         if (land_slot_s == 2'd0) begin
            skid0_n_s = ram_rdata;
         end else begin
            skid1_n_s = ram_rdata;
         end
      end else begin
         skid1_n_s = skid1_r;
      end
      skid_occ_n_s = land_slot_s + {1'b0, pend_r};
   end

   // State registers with synchronous reset; in-flight fetch data is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r   <= {(ADDR_WIDTH+1){1'b0}};
         rd_ptr_r   <= {(ADDR_WIDTH+1){1'b0}};
         pend_r     <= 1'b0;
         skid_occ_r <= 2'd0;
         skid0_r    <= {DATA_WIDTH{1'b0}};
         skid1_r    <= {DATA_WIDTH{1'b0}};
      end else begin
         wr_ptr_r   <= wr_ptr_n_s;
         rd_ptr_r   <= rd_ptr_n_s;
         pend_r     <= pend_n_s;
         skid_occ_r <= skid_occ_n_s;
         skid0_r    <= skid0_n_s;
         skid1_r    <= skid1_n_s;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign out_data  = skid0_r;
   assign count     = count_s;
   assign full      = full_s;
   assign empty     = (count_s == {(ADDR_WIDTH+2){1'b0}});
   assign ram_we    = in_hs_s;
   assign ram_waddr = wr_ptr_r[ADDR_WIDTH-1:0];
   assign ram_wdata = in_data;
   assign ram_raddr = rd_ptr_r[ADDR_WIDTH-1:0];

`ifdef FIFO_SYNC_ALMOST_EN
   assign almost_full  = (count_s >= AFULL_C);
   assign almost_empty = (count_s <= AEMPTY_C);
`else
   localparam logic ALMOST_EN_C = 1'b0;
   assign almost_full  = ALMOST_EN_C & (count_s >= AFULL_C);
   assign almost_empty = ALMOST_EN_C & (count_s <= AEMPTY_C);
`endif

endmodule

// File: tb/tb_fifo_sync_ctl.sv
// Directed bench for fifo_sync_ctl with a behavioural registered-read RAM.
module tb_fifo_sync_ctl;
   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk, reset;
   logic [DW-1:0] in_data, out_data, ram_wdata, ram_rdata;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [AW+1:0] count;
   logic          full, empty, almost_full, almost_empty, ram_we;
   logic [AW-1:0] ram_waddr, ram_raddr;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] mem [0:(1<<AW)-1];

   fifo_sync_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count),
      .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr),
      .ram_rdata(ram_rdata));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
   end

   task automatic cyc_begin(input logic iv, input logic [DW-1:0] id, input logic ordy);
      in_valid = iv; in_data = id; out_ready = ordy;
      @(negedge clk);
   endtask

   task automatic cyc_end;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      logic exp_ae;
`ifdef FIFO_SYNC_ALMOST_EN
      exp_ae = 1'b1;
`else
      exp_ae = 1'b0;
`endif
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         cyc_begin(1'b1, 8'h55, 1'b1);
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
         n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
         n_checks++; if (full !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL reset_flags: full=%b empty=%b want 0/1", full, empty); end
         n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
         n_checks++; if (almost_full !== 1'b0 || almost_empty !== exp_ae) begin n_fail++; $display("FAIL reset_almost: af=%b ae=%b want 0/%b", almost_full, almost_empty, exp_ae); end
         cyc_end;
      end
      reset = 1'b0;
      cyc_begin(1'b0, 8'h00, 1'b0);
      n_checks++; if (in_ready !== 1'b1 || empty !== 1'b1) begin n_fail++; $display("FAIL post_reset: in_ready=%b empty=%b want 1/1", in_ready, empty); end
      cyc_end;
   endtask

   task automatic test_single;
      cyc_begin(1'b1, 8'hA5, 1'b1);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", in_ready); end
      cyc_end;
      for (int c = 1; c <= 4; c++) begin
         cyc_begin(1'b0, 8'h00, 1'b1);
         if (c < 3) begin
            n_checks++; if (out_valid !== 1'b0 || count !== 6'd1) begin n_fail++; $display("FAIL single_c%0d: out_valid=%b count=%0d want 0/1", c, out_valid, count); end
         end else if (c == 3) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 6'd1) begin n_fail++; $display("FAIL single_out: valid=%b data=%h count=%0d want 1/a5/1", out_valid, out_data, count); end
         end else begin
            n_checks++; if (count !== 6'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_after: count=%0d empty=%b valid=%b want 0/1/0", count, empty, out_valid); end
         end
         cyc_end;
      end
   endtask

   task automatic test_fill;
      int acc = 0;
      logic [DW-1:0] exp_d;
      for (int c = 0; c < 24; c++) begin
         cyc_begin(1'b1, 8'h10 + acc[7:0], 1'b0);
         n_checks++; if (count !== acc[5:0]) begin n_fail++; $display("FAIL fill_count c%0d: got %0d want %0d", c, count, acc); end
`ifdef FIFO_SYNC_ALMOST_EN
         n_checks++; if (almost_full !== (acc >= 12) || almost_empty !== (acc <= 2)) begin n_fail++; $display("FAIL fill_almost acc=%0d: af=%b ae=%b", acc, almost_full, almost_empty); end
`else
         n_checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin n_fail++; $display("FAIL fill_almost_tied: af=%b ae=%b want 0/0", almost_full, almost_empty); end
`endif
         if (acc >= 18) begin
            n_checks++; if (in_ready !== 1'b0 || ram_we !== 1'b0 || full !== 1'b1) begin n_fail++; $display("FAIL fill_full: in_ready=%b ram_we=%b full=%b want 0/0/1", in_ready, ram_we, full); end
         end
         if (in_valid && in_ready) begin q.push_back(in_data); acc++; end
         cyc_end;
      end
      n_checks++; if (acc != 18) begin n_fail++; $display("FAIL fill_accepted: got %0d want 18", acc); end
      for (int c = 0; c < 40 && q.size() > 0; c++) begin
         cyc_begin(1'b0, 8'h00, 1'b1);
         n_checks++; if (count !== 6'(q.size())) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", count, q.size()); end
         if (c == 0) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_c0_in_ready: got %b want 0", in_ready); end
         end else if (c == 1) begin
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_reopen: got %b want 1", in_ready); end
         end
         if (out_valid) begin
            exp_d = q.pop_front();
            n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL drain_data: got %h want %h", out_data, exp_d); end
         end
         cyc_end;
      end
      cyc_begin(1'b0, 8'h00, 1'b0);
      n_checks++; if (q.size() != 0 || count !== 6'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL drain_end: left=%0d count=%0d empty=%b", q.size(), count, empty); end
      cyc_end;
   endtask

   task automatic test_stream;
      int sent = 0, got = 0;
      for (int c = 0; c < 120 && got < 100; c++) begin
         cyc_begin(sent < 100, sent[7:0], 1'b1);
         n_checks++; if (count !== 6'(q.size())) begin n_fail++; $display("FAIL stream_count c%0d: got %0d want %0d", c, count, q.size()); end
         if (in_valid && in_ready) begin q.push_back(in_data); sent++; end
         if (out_valid) begin
            void'(q.pop_front());
            n_checks++; if (out_data !== got[7:0] || c != got + 3) begin n_fail++; $display("FAIL stream_word: data=%h cycle=%0d want %h at %0d", out_data, c, got[7:0], got + 3); end
            got++;
         end
         cyc_end;
      end
      n_checks++; if (got != 100) begin n_fail++; $display("FAIL stream_total: got %0d want 100", got); end
   endtask

   task automatic test_backpressure;
      int sent = 0, got = 0;
      logic stalled = 1'b0;
      logic [DW-1:0] prev_d = 8'h00, exp_d;
      for (int c = 0; c < 200 && got < 30; c++) begin
         cyc_begin(sent < 30, 8'h80 + sent[7:0], ~c[0]);
         n_checks++; if (count !== 6'(q.size())) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", count, q.size()); end
         if (stalled) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== prev_d) begin n_fail++; $display("FAIL bp_hold: valid=%b data=%h want 1/%h", out_valid, out_data, prev_d); end
         end
         if (in_valid && in_ready) begin q.push_back(in_data); sent++; end
         if (out_valid && out_ready) begin
            exp_d = q.pop_front();
            n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL bp_data: got %h want %h", out_data, exp_d); end
            got++;
         end
         stalled = out_valid && !out_ready;
         prev_d  = out_data;
         cyc_end;
      end
      n_checks++; if (got != 30) begin n_fail++; $display("FAIL bp_total: got %0d want 30", got); end
   endtask

   task automatic test_wrap;
      int sent = 0, got = 0;
      for (int c = 0; c < 1000 && got < 40; c++) begin
         cyc_begin((sent < 40) && ($urandom_range(0, 1) == 1), sent[7:0], $urandom_range(0, 2) != 0);
         n_checks++; if (count !== 6'(q.size())) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", count, q.size()); end
         if (in_valid && in_ready) begin q.push_back(in_data); sent++; end
         if (out_valid && out_ready) begin
            void'(q.pop_front());
            n_checks++; if (out_data !== got[7:0]) begin n_fail++; $display("FAIL wrap_data: got %h want %h", out_data, got[7:0]); end
            got++;
         end
         cyc_end;
      end
      cyc_begin(1'b0, 8'h00, 1'b0);
      n_checks++; if (got != 40 || count !== 6'd0) begin n_fail++; $display("FAIL wrap_end: got=%0d count=%0d want 40/0", got, count); end
      cyc_end;
   endtask

   task automatic test_reset_midop;
      int n_out = 0;
      for (int k = 0; k < 7; k++) begin
         cyc_begin(1'b1, 8'h20 + k[7:0], 1'b0);
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midop_write%0d: in_ready=%b want 1", k, in_ready); end
         cyc_end;
      end
      cyc_begin(1'b1, 8'h27, 1'b1);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h20) begin n_fail++; $display("FAIL midop_head: valid=%b data=%h want 1/20", out_valid, out_data); end
      cyc_end;
      cyc_begin(1'b0, 8'h00, 1'b0);
      n_checks++; if (count !== 6'd7) begin n_fail++; $display("FAIL midop_count: got %0d want 7", count); end
      reset = 1'b1;
      cyc_end;
      reset = 1'b0;
      cyc_begin(1'b1, 8'h3C, 1'b1);
      n_checks++; if (count !== 6'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midop_after: count=%0d valid=%b in_ready=%b want 0/0/1", count, out_valid, in_ready); end
      cyc_end;
      for (int c = 1; c <= 8; c++) begin
         cyc_begin(1'b0, 8'h00, 1'b1);
         if (out_valid) begin
            n_out++;
            n_checks++; if (out_data !== 8'h3C || c != 3) begin n_fail++; $display("FAIL midop_word: data=%h cycle=%0d want 3c at 3", out_data, c); end
         end
         cyc_end;
      end
      cyc_begin(1'b0, 8'h00, 1'b0);
      n_checks++; if (n_out != 1 || count !== 6'd0) begin n_fail++; $display("FAIL midop_alone: words=%0d count=%0d want 1/0", n_out, count); end
      cyc_end;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      #1;
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_backpressure();
      test_wrap();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
